mini_alu_pipe: RTL

Parametrised two-stage (fetch/execute) successor of the experiment-1 mini ALU core, with configurable data width, data-RAM depth and LED width. It adds SUB/AND/OR, a single-level CALL/RET, HALT, and an explicit branch-flush rule.
- Fetches from an external asynchronous instruction ROM.
- Executes against an internal dual-read-port data RAM.
- Drives a LED register.
- Sits at the board top level between the instruction ROM and the LED pins.

---
 rtl/mini_alu_pkg.sv | 37 +++
 rtl/dual_read_ram.sv | 33 +++
 rtl/mini_alu_pipe.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mini_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mini_alu_pkg
// Brief   : Opcode constants and instruction field-slice helpers for mini_alu_pipe
// Revision: 1.0
// ============================================================================
package mini_alu_pkg;

    localparam logic [3:0] c_OP_NOP  = 4'd0;
    localparam logic [3:0] c_OP_ADD  = 4'd1;
    localparam logic [3:0] c_OP_SUB  = 4'd2;
    localparam logic [3:0] c_OP_AND  = 4'd3;
    localparam logic [3:0] c_OP_OR   = 4'd4;
    localparam logic [3:0] c_OP_STO  = 4'd5;
    localparam logic [3:0] c_OP_BLE  = 4'd6;
    localparam logic [3:0] c_OP_JMP  = 4'd7;
    localparam logic [3:0] c_OP_LED  = 4'd8;
    localparam logic [3:0] c_OP_CALL = 4'd9;
    localparam logic [3:0] c_OP_RET  = 4'd10;
    localparam logic [3:0] c_OP_HALT = 4'd15;

    // Field index within the instruction word, counted from the LSB in ADDR_WIDTH units
    localparam int c_FLD_SRC0 = 0;
    localparam int c_FLD_SRC1 = 1;
    localparam int c_FLD_DEST = 2;
    localparam int c_FLD_OP   = 3;

    function automatic int f_instr_width(input int aw);
        return 4 + 3 * aw;
    endfunction

    function automatic int f_field_lsb(input int aw, input int fld);
        return fld * aw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_read_ram.sv
`default_nettype none
// ============================================================================
// Module  : dual_read_ram
// Brief   : Data RAM with two asynchronous read ports and one synchronous write port
// Revision: 1.0
// ============================================================================
module dual_read_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr0,
    output logic [DATA_WIDTH-1:0] o_rdata0,
    input  logic [ADDR_WIDTH-1:0] i_raddr1,
    output logic [DATA_WIDTH-1:0] o_rdata1
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata0 = r_mem[i_raddr0];
    assign o_rdata1 = r_mem[i_raddr1];

endmodule
`default_nettype wire

// File: rtl/mini_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module  : mini_alu_pipe
// Brief   : Two-stage fetch/execute mini ALU core with CALL/RET, HALT and LED output
// Revision: 1.0
// ============================================================================
module mini_alu_pipe
    import mini_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int IP_WIDTH   = 16,
    parameter int LED_WIDTH  = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [4+3*ADDR_WIDTH-1:0]   iInstruction,
    output logic [IP_WIDTH-1:0]         oIP,
    output logic [LED_WIDTH-1:0]        oLed,
    output logic                        oHalted
);

    localparam int c_OP_LSB   = f_field_lsb(ADDR_WIDTH, c_FLD_OP);
    localparam int c_DEST_LSB = f_field_lsb(ADDR_WIDTH, c_FLD_DEST);
    localparam int c_SRC1_LSB = f_field_lsb(ADDR_WIDTH, c_FLD_SRC1);
    localparam int c_SRC0_LSB = f_field_lsb(ADDR_WIDTH, c_FLD_SRC0);
    localparam int c_IMM_W    = 2 * ADDR_WIDTH;
    localparam logic [IP_WIDTH-1:0] c_IP_ONE = IP_WIDTH'(1);

    logic [IP_WIDTH-1:0]   r_ip;
    logic [3:0]            r_ex_op;
    logic [ADDR_WIDTH-1:0] r_ex_dest;
    logic [ADDR_WIDTH-1:0] r_ex_src1;
    logic [ADDR_WIDTH-1:0] r_ex_src0;
    logic [IP_WIDTH-1:0]   r_ex_pc;
    logic [IP_WIDTH-1:0]   r_ret;
    logic [LED_WIDTH-1:0]  r_led;
    logic                  r_halted;

    logic [3:0]            w_fetch_op;
    logic [ADDR_WIDTH-1:0] w_fetch_dest;
    logic [ADDR_WIDTH-1:0] w_fetch_src1;
    logic [ADDR_WIDTH-1:0] w_fetch_src0;
    logic [DATA_WIDTH-1:0] w_d0;
    logic [DATA_WIDTH-1:0] w_d1;
    logic [c_IMM_W-1:0]    w_imm_raw;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [IP_WIDTH-1:0]   w_dest_ip;
    logic [IP_WIDTH-1:0]   w_target;
    logic                  w_taken;
    logic                  w_halt;
    logic                  w_alu_we;
    logic                  w_ram_we;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_fetch_op   = iInstruction[c_OP_LSB   +: 4];
    assign w_fetch_dest = iInstruction[c_DEST_LSB +: ADDR_WIDTH];
    assign w_fetch_src1 = iInstruction[c_SRC1_LSB +: ADDR_WIDTH];
    assign w_fetch_src0 = iInstruction[c_SRC0_LSB +: ADDR_WIDTH];

    assign w_imm_raw = {r_ex_src1, r_ex_src0};

    generate
        if (c_IMM_W >= DATA_WIDTH) begin : g_imm_trunc
            assign w_imm = w_imm_raw[DATA_WIDTH-1:0];
        end else begin : g_imm_zext
            assign w_imm = {{(DATA_WIDTH-c_IMM_W){1'b0}}, w_imm_raw};
        end
    endgenerate

    generate
        if (IP_WIDTH >= ADDR_WIDTH) begin : g_dest_zext
            assign w_dest_ip = {{(IP_WIDTH-ADDR_WIDTH){1'b0}}, r_ex_dest};
        end else begin : g_dest_trunc
            assign w_dest_ip = r_ex_dest[IP_WIDTH-1:0];
        end
    endgenerate

    dual_read_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk      (Clock),
        .i_we     (w_ram_we),
        .i_waddr  (r_ex_dest),
        .i_wdata  (w_wdata),
        .i_raddr0 (r_ex_src0),
        .o_rdata0 (w_d0),
        .i_raddr1 (r_ex_src1),
        .o_rdata1 (w_d1)
    );

    always_comb begin
        w_alu_we = 1'b0;
        w_wdata  = '0;
        w_taken  = 1'b0;
        w_target = w_dest_ip;
        case (r_ex_op)
            c_OP_ADD:  begin w_alu_we = 1'b1; w_wdata = w_d1 + w_d0; end
            c_OP_SUB:  begin w_alu_we = 1'b1; w_wdata = w_d1 - w_d0; end
            c_OP_AND:  begin w_alu_we = 1'b1; w_wdata = w_d1 & w_d0; end
            c_OP_OR:   begin w_alu_we = 1'b1; w_wdata = w_d1 | w_d0; end
            c_OP_STO:  begin w_alu_we = 1'b1; w_wdata = w_imm;       end
            c_OP_BLE:  w_taken = (w_d1 <= w_d0);
            c_OP_JMP:  w_taken = 1'b1;
            c_OP_CALL: w_taken = 1'b1;
            c_OP_RET:  begin w_taken = 1'b1; w_target = r_ret; end
            default:   ;
        endcase
    end

    assign w_halt = (r_ex_op == c_OP_HALT);
    // A write must never land while reset is held, even on a clock edge.
    assign w_ram_we = w_alu_we & Reset;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_ip      <= '0;
            r_ex_op   <= c_OP_NOP;
            r_ex_dest <= '0;
            r_ex_src1 <= '0;
            r_ex_src0 <= '0;
            r_ex_pc   <= '0;
            r_ret     <= '0;
            r_led     <= '0;
            r_halted  <= 1'b0;
        end else if (w_halt) begin
            // HALT stays in the execute register, so the freeze is self-sustaining.
            r_halted <= 1'b1;
        end else begin
            if (r_ex_op == c_OP_CALL) begin
                r_ret <= r_ex_pc + c_IP_ONE;
            end
            if (r_ex_op == c_OP_LED) begin
                r_led <= w_d1[LED_WIDTH-1:0];
            end
            if (w_taken) begin
                r_ip      <= w_target;
                r_ex_op   <= c_OP_NOP;
                r_ex_dest <= '0;
                r_ex_src1 <= '0;
                r_ex_src0 <= '0;
                r_ex_pc   <= r_ip;
            end else begin
                r_ip      <= r_ip + c_IP_ONE;
                r_ex_op   <= w_fetch_op;
                r_ex_dest <= w_fetch_dest;
                r_ex_src1 <= w_fetch_src1;
                r_ex_src0 <= w_fetch_src0;
                r_ex_pc   <= r_ip;
            end
        end
    end

    assign oIP     = r_ip;
    assign oLed    = r_led;
    assign oHalted = r_halted;

endmodule
`default_nettype wire
